// File: rtl/regfile_writeback_ctrl_if.sv
// Signal bundle between the execute/memory stages and the register-file write-back controller.
// The master drives results and issue info; the slave returns handshakes, scoreboard and write port.
interface regfile_writeback_ctrl_if #(
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  logic            alu_valid;
  logic [4:0]      alu_rd;
  logic [31:0]     alu_data;
  logic            alu_stall;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [4:0]      lsu_rd;
  logic [31:0]     lsu_data;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [31:0]     pending;
  logic            reg_wr;
  logic [4:0]      waddr;
  logic [31:0]     wdata;
  logic [CntW-1:0] fifo_count;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, issue_valid, issue_rd,
    input  alu_stall, lsu_ready, pending, reg_wr, waddr, wdata, fifo_count
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data, issue_valid, issue_rd,
    output alu_stall, lsu_ready, pending, reg_wr, waddr, wdata, fifo_count
  );
endinterface

// File: rtl/regfile_writeback_ctrl.sv
// Register-file write-port arbiter: ALU results take priority, LSU results queue in a FIFO
// that is forced through after STARVE_MAX blocked cycles; tracks in-flight long-latency dests.
module regfile_writeback_ctrl #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic                    clk,
  input logic                    reset,
  regfile_writeback_ctrl_if.slave bus
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned StvW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  logic [4:0]      r_rd_mem   [FIFO_DEPTH];
  logic [31:0]     r_data_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  logic [CntW-1:0] r_count;
  logic [StvW-1:0] r_starve;
  logic [31:0]     r_pending;
  logic            r_reg_wr;
  logic [4:0]      r_waddr;
  logic [31:0]     r_wdata;

  logic            w_empty;
  logic            w_ready;
  logic            w_stall;
  logic            w_alu_acc;
  logic            w_lsu_acc;
  logic            w_push;
  logic            w_pop;
  logic [4:0]      w_head_rd;
  logic [31:0]     w_head_data;
  logic [31:0]     w_pending_nxt;

  assign w_empty     = (r_count == '0);
  assign w_ready     = reset & (r_count < CntW'(FIFO_DEPTH));
  assign w_stall     = reset & ~w_empty & (r_starve == StvW'(STARVE_MAX));
  assign w_alu_acc   = bus.alu_valid & ~w_stall;
  assign w_lsu_acc   = bus.lsu_valid & w_ready;
  // rd=0 results complete the handshake but never occupy a slot
  assign w_push      = w_lsu_acc & (bus.lsu_rd != 5'd0);
  assign w_pop       = ~w_alu_acc & ~w_empty;
  assign w_head_rd   = r_rd_mem[r_rptr];
  assign w_head_data = r_data_mem[r_rptr];

  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) begin
      w_pending_nxt[w_head_rd] = 1'b0;
    end
    // A re-issue in the same cycle as the pop keeps the register pending
    if (bus.issue_valid && (bus.issue_rd != 5'd0)) begin
      w_pending_nxt[bus.issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rd_mem[r_wptr]   <= bus.lsu_rd;
      r_data_mem[r_wptr] <= bus.lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_starve  <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_push) begin
        r_wptr <= r_wptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PtrW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      if (w_pop || w_empty) begin
        r_starve <= '0;
      end else if (w_alu_acc) begin
        r_starve <= r_starve + StvW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_reg_wr <= 1'b0;
      r_waddr  <= 5'd0;
      r_wdata  <= 32'd0;
    end else if (w_alu_acc) begin
      r_reg_wr <= (bus.alu_rd != 5'd0);
      if (bus.alu_rd != 5'd0) begin
        r_waddr <= bus.alu_rd;
        r_wdata <= bus.alu_data;
      end
    end else if (w_pop) begin
      r_reg_wr <= 1'b1;
      r_waddr  <= w_head_rd;
      r_wdata  <= w_head_data;
    end else begin
      r_reg_wr <= 1'b0;
    end
  end

  assign bus.alu_stall  = w_stall;
  assign bus.lsu_ready  = w_ready;
  assign bus.pending    = r_pending;
  assign bus.reg_wr     = r_reg_wr;
  assign bus.waddr      = r_waddr;
  assign bus.wdata      = r_wdata;
  assign bus.fifo_count = r_count;
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Bench for regfile_writeback_ctrl: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_regfile_writeback_ctrl;
  localparam int unsigned Depth     = 4;
  localparam int unsigned StarveMax = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_ctrl_if #(.FIFO_DEPTH(Depth)) ifc ();

  regfile_writeback_ctrl #(
    .FIFO_DEPTH(Depth),
    .STARVE_MAX(StarveMax)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_pend;
  logic        m_wr;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  int          m_starve;
  bit          m_known = 1'b0;

  // Reference model: compare at negedge, then advance to the state after the coming edge
  always @(negedge clk) begin
    logic e_stall, e_ready, alu_acc, lsu_acc, pop, was_empty;
    ent_t h, n;
    e_stall = reset && (m_q.size() != 0) && (m_starve == StarveMax);
    e_ready = reset && (m_q.size() < Depth);
    if (m_known) begin
      chk("reg_wr", 32'(ifc.reg_wr), 32'(m_wr));
      chk("waddr", 32'(ifc.waddr), 32'(m_waddr));
      chk("wdata", ifc.wdata, m_wdata);
      chk("pending", ifc.pending, m_pend);
      chk("fifo_count", 32'(ifc.fifo_count), 32'(m_q.size()));
      chk("alu_stall", 32'(ifc.alu_stall), 32'(e_stall));
      chk("lsu_ready", 32'(ifc.lsu_ready), 32'(e_ready));
    end
    if (!reset) begin
      m_q.delete();
      m_pend = '0; m_wr = 1'b0; m_waddr = '0; m_wdata = '0; m_starve = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      alu_acc   = ifc.alu_valid && !e_stall;
      lsu_acc   = ifc.lsu_valid && e_ready;
      was_empty = (m_q.size() == 0);
      pop       = !alu_acc && !was_empty;
      if (pop) begin
        h = m_q.pop_front();
        m_pend[h.rd] = 1'b0;
      end
      if (alu_acc) begin
        m_wr = (ifc.alu_rd != 0);
        if (ifc.alu_rd != 0) begin
          m_waddr = ifc.alu_rd;
          m_wdata = ifc.alu_data;
        end
      end else if (pop) begin
        m_wr = 1'b1; m_waddr = h.rd; m_wdata = h.data;
      end else begin
        m_wr = 1'b0;
      end
      if (pop || was_empty) m_starve = 0;
      else if (alu_acc) m_starve++;
      if (lsu_acc && ifc.lsu_rd != 0) begin
        n.rd = ifc.lsu_rd; n.data = ifc.lsu_data;
        m_q.push_back(n);
      end
      if (ifc.issue_valid && ifc.issue_rd != 0) m_pend[ifc.issue_rd] = 1'b1;
    end
  end

  // Write log and occupancy/stall observation for the directed scenarios
  bit         log_en = 1'b0;
  logic [4:0] wlog[$];
  int         max_count = 0;
  int         stall_cnt = 0;
  always @(negedge clk) begin
    if (log_en) begin
      if (ifc.reg_wr === 1'b1) wlog.push_back(ifc.waddr);
      if (int'(ifc.fifo_count) > max_count) max_count = int'(ifc.fifo_count);
      if (ifc.alu_stall === 1'b1) stall_cnt++;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  bit saw_full = 1'b0;
  task automatic lsu_push(input logic [4:0] rd, input logic [31:0] d);
    ifc.lsu_valid = 1'b1; ifc.lsu_rd = rd; ifc.lsu_data = d;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (ifc.lsu_ready === 1'b1) begin
        cyc();
        ifc.lsu_valid = 1'b0;
        return;
      end
      saw_full = 1'b1;
      cyc();
    end
    ifc.lsu_valid = 1'b0;
    checks++; errors++;
    $display("FAIL lsu_push_timeout actual=ready_low required=accept_within_20");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    ifc.alu_valid = 0; ifc.alu_rd = 0; ifc.alu_data = 0;
    ifc.lsu_valid = 0; ifc.lsu_rd = 0; ifc.lsu_data = 0;
    ifc.issue_valid = 0; ifc.issue_rd = 0;
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
    chk("rst_reg_wr", 32'(ifc.reg_wr), 32'd0);
    chk("rst_pending", ifc.pending, 32'd0);
    chk("rst_fifo_count", 32'(ifc.fifo_count), 32'd0);
    idle(1);

    // 1: single ALU write
    ifc.alu_valid = 1; ifc.alu_rd = 5; ifc.alu_data = 32'hDEADBEEF;
    cyc();
    ifc.alu_valid = 0;
    chk("t1_reg_wr", 32'(ifc.reg_wr), 32'd1);
    chk("t1_waddr", 32'(ifc.waddr), 32'd5);
    chk("t1_wdata", ifc.wdata, 32'hDEADBEEF);
    cyc();
    chk("t1_reg_wr_drop", 32'(ifc.reg_wr), 32'd0);
    chk("t1_wdata_hold", ifc.wdata, 32'hDEADBEEF);

    // 2: fill FIFO (ALU occupies the port with rd=0 results) and check order
    log_en = 1'b1; wlog.delete(); max_count = 0;
    ifc.alu_valid = 1; ifc.alu_rd = 0; ifc.alu_data = 32'h0;
    for (int i = 1; i <= 5; i++) lsu_push(5'(i), 32'(i * 16 + i));
    ifc.alu_valid = 0;
    idle(8);
    log_en = 1'b0;
    chk("t2_saw_full", 32'(saw_full), 32'd1);
    chk("t2_max_count", 32'(max_count), 32'd4);
    chk("t2_nwrites", 32'(wlog.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < wlog.size()) chk("t2_order", 32'(wlog[i]), 32'(i + 1));
    end

    // 3: starvation with two queued entries
    stall_cnt = 0;
    ifc.alu_valid = 1; ifc.alu_rd = 7; ifc.alu_data = 32'h7777;
    ifc.lsu_valid = 1; ifc.lsu_rd = 1; ifc.lsu_data = 32'hA1;
    cyc();
    ifc.lsu_rd = 2; ifc.lsu_data = 32'hA2;
    cyc();
    ifc.lsu_valid = 0;
    log_en = 1'b1;
    idle(12);
    log_en = 1'b0;
    ifc.alu_valid = 0;
    chk("t3_stalls", 32'(stall_cnt), 32'd2);
    chk("t3_drained", 32'(ifc.fifo_count), 32'd0);
    idle(2);

    // 4: scoreboard set/clear, and set winning over clear
    ifc.issue_valid = 1; ifc.issue_rd = 9;
    cyc();
    ifc.issue_valid = 0;
    chk("t4_pend_set", ifc.pending, 32'h0000_0200);
    ifc.lsu_valid = 1; ifc.lsu_rd = 9; ifc.lsu_data = 32'h99;
    cyc();
    ifc.lsu_valid = 0;
    chk("t4_pend_inflight", ifc.pending, 32'h0000_0200);
    cyc();
    chk("t4_wr9", 32'(ifc.reg_wr), 32'd1);
    chk("t4_waddr9", 32'(ifc.waddr), 32'd9);
    chk("t4_pend_clr", ifc.pending, 32'h0);
    ifc.issue_valid = 1; ifc.issue_rd = 9;
    cyc();
    ifc.issue_valid = 0;
    ifc.lsu_valid = 1; ifc.lsu_rd = 9; ifc.lsu_data = 32'h98;
    cyc();
    ifc.lsu_valid = 0;
    ifc.issue_valid = 1; ifc.issue_rd = 9;
    cyc();
    ifc.issue_valid = 0;
    chk("t4_setwins_wr", 32'(ifc.reg_wr), 32'd1);
    chk("t4_setwins_pend", ifc.pending, 32'h0000_0200);

    // 5: x0 handling
    ifc.alu_valid = 1; ifc.alu_rd = 0; ifc.alu_data = 32'h1234;
    ifc.lsu_valid = 1; ifc.lsu_rd = 0; ifc.lsu_data = 32'h5678;
    ifc.issue_valid = 1; ifc.issue_rd = 0;
    cyc();
    ifc.alu_valid = 0; ifc.lsu_valid = 0; ifc.issue_valid = 0;
    chk("t5_no_wr", 32'(ifc.reg_wr), 32'd0);
    chk("t5_count", 32'(ifc.fifo_count), 32'd0);
    chk("t5_pend", ifc.pending, 32'h0000_0200);
    cyc();
    chk("t5_no_wr_late", 32'(ifc.reg_wr), 32'd0);

    // 6: reset with three entries queued
    ifc.alu_valid = 1; ifc.alu_rd = 0;
    ifc.lsu_valid = 1; ifc.issue_valid = 1;
    ifc.lsu_rd = 1; ifc.lsu_data = 32'hB1; ifc.issue_rd = 1;
    cyc();
    ifc.lsu_rd = 2; ifc.lsu_data = 32'hB2; ifc.issue_rd = 2;
    cyc();
    ifc.lsu_rd = 9; ifc.lsu_data = 32'hB9; ifc.issue_rd = 9;
    cyc();
    ifc.lsu_valid = 0; ifc.issue_valid = 0;
    chk("t6_count3", 32'(ifc.fifo_count), 32'd3);
    chk("t6_pend", ifc.pending, 32'h0000_0206);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    ifc.alu_valid = 0;
    #1;
    chk("t6_count0", 32'(ifc.fifo_count), 32'd0);
    chk("t6_pend0", ifc.pending, 32'd0);
    chk("t6_ready", 32'(ifc.lsu_ready), 32'd1);
    log_en = 1'b1; wlog.delete();
    idle(5);
    log_en = 1'b0;
    chk("t6_no_writes", 32'(wlog.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
